// File: rtl/game_flow_ctrl_if.sv
// Game sequencer bus: the raw inputs from the board and the bird controller,
// plus the state and pulse outputs that go to the display datapath.
// master = the side that drives the inputs (board/datapath wrapper)
// slave  = game_flow_ctrl itself
interface game_flow_ctrl_if #(
    parameter int SCORE_W = 8
);
    logic               tick_ms;
    logic               up_button;
    logic               pause_sw;
    logic               isDead;
    logic [SCORE_W-1:0] score;
    logic [1:0]         state;
    logic               flap;
    logic               round_clr;
    logic [SCORE_W-1:0] best_score;
    logic               new_best;

    modport master (
        output tick_ms, up_button, pause_sw, isDead, score,
        input  state, flap, round_clr, best_score, new_best
    );

    modport slave (
        input  tick_ms, up_button, pause_sw, isDead, score,
        output state, flap, round_clr, best_score, new_best
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Flappy Bird game sequencer.
// Synchronises the flap button and pause switch, runs the READY/PLAY/OVER/PAUSE
// flow, holds off restarts for LOCK_MS milliseconds after a death, and
// (when BEST_SCORE_EN is defined) tracks the best score since reset.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  READY  | waiting for the first press; prompt overlay shown
//  PLAY   | round running; presses become flap pulses
//  OVER   | bird died; restart allowed once the lock-out has expired
//  PAUSE  | round frozen while the pause switch is on
module game_flow_ctrl #(
    parameter int SCORE_W = 8,
    parameter int LOCK_MS = 500,
    parameter int LOCK_W  = 10
) (
    input  logic            clk,
    input  logic            rst,
    game_flow_ctrl_if.slave bus
);

    localparam logic [1:0] ST_READY = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_OVER  = 2'd2;
    localparam logic [1:0] ST_PAUSE = 2'd3;

    localparam logic [LOCK_W-1:0] LOCK_INIT = LOCK_W'(LOCK_MS);

    logic              btn_s1;
    logic              btn_s2;
    logic              btn_d;
    logic              pause_s1;
    logic              pause_s2;
    logic              press;
    logic              started_q;

    logic [1:0]        state_q;
    logic [1:0]        state_nx;
    logic              flap_q;
    logic              flap_nx;
    logic              clr_q;
    logic              clr_nx;
    logic              load_lock;
    logic [LOCK_W-1:0] lock_q;

    // Two-flop synchronisers; the button gets a third flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1   <= 1'b0;
            btn_s2   <= 1'b0;
            btn_d    <= 1'b0;
            pause_s1 <= 1'b0;
            pause_s2 <= 1'b0;
        end else begin
            btn_s1   <= bus.up_button;
            btn_s2   <= btn_s1;
            btn_d    <= btn_s2;
            pause_s1 <= bus.pause_sw;
            pause_s2 <= pause_s1;
        end
    end

    // A held button yields a single press on its rising edge
    assign press = btn_s2 & ~btn_d;

    // Marks that the first clock after reset release has happened
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started_q <= 1'b0;
        end else begin
            started_q <= 1'b1;
        end
    end

    // Next-state and pulse decode; the very first clock after reset also clears the datapath
    always_comb begin
        state_nx  = state_q;
        flap_nx   = 1'b0;
        clr_nx    = ~started_q;
        load_lock = 1'b0;
        case (state_q)
            ST_READY: begin
                if (press) begin
                    state_nx = ST_PLAY;
                    flap_nx  = 1'b1;
                    clr_nx   = 1'b1;
                end
            end
            ST_PLAY: begin
                // Death wins over pause and swallows a coincident press
                if (bus.isDead) begin
                    state_nx  = ST_OVER;
                    load_lock = 1'b1;
                end else if (pause_s2) begin
                    state_nx = ST_PAUSE;
                end else if (press) begin
                    flap_nx = 1'b1;
                end
            end
            ST_OVER: begin
                if (press && (lock_q == '0)) begin
                    state_nx = ST_READY;
                    clr_nx   = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (!pause_s2) begin
                    state_nx = ST_PLAY;
                end
            end
            default: begin
                state_nx = ST_READY;
            end
        endcase
    end

    // Registered state and one-cycle pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_READY;
            flap_q  <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_nx;
            flap_q  <= flap_nx;
            clr_q   <= clr_nx;
        end
    end

    // Restart lock-out: loaded on death, counts tick_ms down to zero while in OVER
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q <= '0;
        end else if (load_lock) begin
            lock_q <= LOCK_INIT;
        end else if ((state_q == ST_OVER) && bus.tick_ms && (lock_q != '0)) begin
            lock_q <= lock_q - 1'b1;
        end
    end

    assign bus.state     = state_q;
    assign bus.flap      = flap_q;
    assign bus.round_clr = clr_q;

`ifdef BEST_SCORE_EN
    logic [SCORE_W-1:0] best_q;
    logic               new_best_q;

    // Best score captured at the moment of death; ties do not count as a new best
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_q     <= '0;
            new_best_q <= 1'b0;
        end else if ((state_q == ST_PLAY) && bus.isDead) begin
            if (bus.score > best_q) begin
                best_q     <= bus.score;
                new_best_q <= 1'b1;
            end else begin
                new_best_q <= 1'b0;
            end
        end else if ((state_q == ST_OVER) && (state_nx != ST_OVER)) begin
            new_best_q <= 1'b0;
        end
    end

    assign bus.best_score = best_q;
    assign bus.new_best   = new_best_q;
`else
    // Score is not needed when best-score tracking is left out
    logic [SCORE_W-1:0] unused_score;
    assign unused_score   = bus.score;

    assign bus.best_score = '0;
    assign bus.new_best   = 1'b0;
`endif

endmodule
